// File: rtl/training_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : training_feeder
// Brief    : Holds a set of training cases and streams one case per pass into
//            the DNN in per-clock chunks. The absolute output-layer error of
//            each pass is summed and reported with a one-cycle valid pulse.
//            Optional macro FEEDER_LFSR_EN builds the random (LFSR) case order.
// Revision : 1.0  initial release
// ============================================================================
module training_feeder #(
    parameter int WIDTH     = 16,
    parameter int N_IN      = 16,
    parameter int N_OUT     = 4,
    parameter int A_CHUNK   = 4,
    parameter int Y_CHUNK   = 1,
    parameter int CASES     = 8,
    parameter int ERR_WIDTH = 24,
    localparam int c_iw     = $clog2(CASES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 mode,
    input  logic                 load_en,
    input  logic [c_iw-1:0]      load_addr,
    input  logic [N_IN-1:0]      load_a,
    input  logic [N_OUT-1:0]     load_y,
    input  logic [WIDTH-1:0]     dL,
    output logic [A_CHUNK-1:0]   act_in,
    output logic [Y_CHUNK-1:0]   y_in,
    output logic                 busy,
    output logic [c_iw-1:0]      case_idx,
    output logic [ERR_WIDTH-1:0] err_sum,
    output logic                 err_valid
);

    localparam int c_chunks = N_IN / A_CHUNK;
    localparam int c_cw     = $clog2(c_chunks + 2);
    localparam logic [c_cw-1:0] c_last_chunk = c_cw'(c_chunks - 1);
    localparam logic [c_cw-1:0] c_last_drain = c_cw'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FEED   = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cw-1:0]      r_cnt;
    logic [c_cw-1:0]      w_cnt_nxt;
    logic                 w_select;
    logic                 w_report;
    logic [c_iw-1:0]      w_sel_idx;
    logic                 w_seq_step;
    logic [c_iw-1:0]      r_seq;

    logic [N_IN-1:0]      r_mem_a [CASES];
    logic [N_OUT-1:0]     r_mem_y [CASES];
    logic [N_IN-1:0]      r_a_sh;
    logic [N_OUT-1:0]     r_y_sh;

    logic [ERR_WIDTH-1:0] r_acc;
    logic [ERR_WIDTH-1:0] w_acc_sum;
    logic [ERR_WIDTH:0]   w_sum_wide;
    logic [WIDTH-1:0]     w_abs;

    // ------------------------------------------------------------------------
    // Case selection
    // ------------------------------------------------------------------------
`ifdef FEEDER_LFSR_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    always_comb begin
        w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        w_sel_idx  = mode ? w_lfsr_nxt[c_iw-1:0] : r_seq;
        w_seq_step = ~mode;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_select && mode) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;

    always_comb begin
        w_sel_idx  = r_seq;
        w_seq_step = 1'b1;
    end
`endif

    // CASES is a power of two, so the natural overflow is the required wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seq <= '0;
        end else if (w_select && w_seq_step) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Pass sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_select    = 1'b0;
        w_report    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_select    = 1'b1;
                    w_state_nxt = S_FEED;
                    w_cnt_nxt   = '0;
                end
            end
            S_FEED: begin
                if (r_cnt == c_last_chunk) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == c_last_drain) begin
                    w_report    = 1'b1;
                    w_state_nxt = S_REPORT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_REPORT: begin
                if (run) begin
                    w_select    = 1'b1;
                    w_state_nxt = S_FEED;
                end else begin
                    w_state_nxt = S_IDLE;
                end
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Case memory (a same-cycle snapshot reads the pre-write contents)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CASES; i++) begin
                r_mem_a[i] <= '0;
                r_mem_y[i] <= '0;
            end
        end else if (load_en) begin
            r_mem_a[load_addr] <= load_a;
            r_mem_y[load_addr] <= load_y;
        end
    end

    // ------------------------------------------------------------------------
    // Error magnitude and saturating accumulation
    // ------------------------------------------------------------------------
    always_comb begin
        // Unsigned reading of the negation gives 2^(WIDTH-1) for the most negative sample.
        w_abs      = dL[WIDTH-1] ? -dL : dL;
        w_sum_wide = {1'b0, r_acc} + {{(ERR_WIDTH + 1 - WIDTH){1'b0}}, w_abs};
        w_acc_sum  = w_sum_wide[ERR_WIDTH] ? {ERR_WIDTH{1'b1}} : w_sum_wide[ERR_WIDTH-1:0];
    end

    // ------------------------------------------------------------------------
    // Stream shifters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh    <= '0;
            r_y_sh    <= '0;
            r_acc     <= '0;
            act_in    <= '0;
            y_in      <= '0;
            busy      <= 1'b0;
            case_idx  <= '0;
            err_sum   <= '0;
            err_valid <= 1'b0;
        end else begin
            busy      <= (w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN);
            err_valid <= w_report;
            if (w_report) begin
                err_sum <= w_acc_sum;
            end
            if (w_select) begin
                case_idx <= w_sel_idx;
                act_in   <= r_mem_a[w_sel_idx][A_CHUNK-1:0];
                y_in     <= r_mem_y[w_sel_idx][Y_CHUNK-1:0];
                r_a_sh   <= r_mem_a[w_sel_idx] >> A_CHUNK;
                r_y_sh   <= r_mem_y[w_sel_idx] >> Y_CHUNK;
                r_acc    <= '0;
            end else begin
                if (busy) begin
                    r_acc <= w_acc_sum;
                end
                if (r_state == S_FEED) begin
                    if (r_cnt == c_last_chunk) begin
                        act_in <= '0;
                        y_in   <= '0;
                    end else begin
                        act_in <= r_a_sh[A_CHUNK-1:0];
                        y_in   <= r_y_sh[Y_CHUNK-1:0];
                        r_a_sh <= r_a_sh >> A_CHUNK;
                        r_y_sh <= r_y_sh >> Y_CHUNK;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
